main_memory_ctrl: RTL

- Parametrised multi-cycle main-memory model that sits behind the cache controller.
- Serves whole-block reads, single-word write-through merges and full-block write-backs with a configurable access latency.
- Handshake is a clean one-cycle mem_done pulse plus a busy flag.
- Generalises block width (words per block), depth and latency over the fixed 128-bit/4-cycle memory, and adds a block write-back path.

---
 rtl/main_memory_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/main_memory_ctrl.sv
// Multi-cycle main-memory model behind the cache controller: block reads, single-word
// merges and block write-backs, each finishing with a one-cycle mem_done pulse.
module main_memory_ctrl #(
  parameter int RISC_data  = 32,
  parameter int WORDS      = 4,
  parameter int main_depth = 256,
  parameter int ADDR_W     = 8,
  parameter int LATENCY    = 4,
  localparam int BLK       = RISC_data * WORDS,
  localparam int WL_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WE,
  input  logic                 RE,
  input  logic                 WB,
  input  logic [RISC_data-1:0] WD_RISC,
  input  logic [WL_W-1:0]      word_loc,
  input  logic [BLK-1:0]       WD_BLK,
  input  logic [ADDR_W-1:0]    A,
  output logic [BLK-1:0]       RD,
  output logic                 mem_done,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OP_RE, OP_WE, OP_WB} op_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t                r_state;
  state_t                w_state_next;
  op_t                   r_op;
  op_t                   w_op_sel;
  logic                  w_accept;
  logic                  w_commit;
  logic [3:0]            r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [WL_W-1:0]       r_wloc;
  logic [RISC_data-1:0]  r_wd;
  logic [BLK-1:0]        r_blk;
  logic [BLK-1:0]        r_rd;
  logic                  r_done;
  logic                  r_busy;

  logic [BLK-1:0]        r_mem [0:main_depth-1];
  logic [BLK-1:0]        r_mem_q;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [BLK-1:0]        w_merged;
  logic [BLK-1:0]        w_mem_wd;
  logic                  w_mem_we;
  logic                  w_addr_ok;
  logic                  w_wloc_ok;

  assign w_op_sel  = WB ? OP_WB : (WE ? OP_WE : OP_RE);
  assign w_addr_ok = ({1'b0, r_addr} < (ADDR_W + 1)'(main_depth));
  assign w_wloc_ok = ({1'b0, r_wloc} < (WL_W + 1)'(WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (WB || WE || RE) begin
          w_accept     = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == LAT) begin
          w_commit     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_RE;
      r_addr <= '0;
      r_wloc <= '0;
      r_wd   <= '0;
      r_blk  <= '0;
      r_cnt  <= '0;
      r_rd   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_op   <= w_op_sel;
        r_addr <= A;
        r_wloc <= word_loc;
        r_wd   <= WD_RISC;
        r_blk  <= WD_BLK;
        r_cnt  <= 4'd1;
        r_busy <= 1'b1;
      end else if (r_state == S_ACCESS && !w_commit) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      if (w_commit && r_op == OP_RE) begin
        r_rd <= w_addr_ok ? r_mem_q : '0;
      end
    end
  end

  // Read port is registered: it follows A while idle and the latched address afterwards,
  // so r_mem_q already holds the target block on the commit edge, even for LATENCY=1.
  assign w_rd_addr = (r_state == S_IDLE) ? A : r_addr;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_merge
      assign w_merged[gi*RISC_data +: RISC_data] =
        (r_wloc == WL_W'(gi)) ? r_wd : r_mem_q[gi*RISC_data +: RISC_data];
    end
  endgenerate

  assign w_mem_wd = (r_op == OP_WB) ? r_blk : w_merged;
  assign w_mem_we = w_commit && w_addr_ok &&
                    ((r_op == OP_WB) || (r_op == OP_WE && w_wloc_ok));

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_mem_wd;
    end
    r_mem_q <= r_mem[w_rd_addr];
  end

  assign RD       = r_rd;
  assign mem_done = r_done;
  assign busy     = r_busy;

endmodule
